// File: rtl/wishbone_cmd_master.sv
// Wishbone classic single-transfer initiator.
// Turns a valid/ready command stream into one bus cycle at a time. Each cycle
// ends with either the slave's ACK or a timeout abort. The result is returned
// on a valid/ready response stream.
//
// Handshake rule, for both the command and the response streams: a beat
// transfers on a rising edge where valid and ready are both high. While valid
// is high, the payload is held stable until that edge.
module wishbone_cmd_master #(
    parameter int ADR_W   = 32,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    // command stream
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    // response stream
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    // wishbone master port
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i,
    // debug view of the FSM state (0 IDLE, 1 BUS, 2 RESP)
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value at which an un-acked strobe is abandoned.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;

    // State and output registers; reset forces every output low at once.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic: accept in IDLE, wait for ACK or timeout in BUS, hand off in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                // ready rises on the first edge after reset release
                ready_d = 1'b1;
                if (cmd_valid_i && ready_q) begin
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_we_i ? cmd_dat_i : 32'h0;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = BUS;
                end
            end
            BUS: begin
                ready_d = 1'b0;
                if (wbm_ack_i) begin
                    // ACK takes priority over a timeout on the same edge
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                        cyc_d       = 1'b0;
                        rsp_dat_d   = 32'h0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                ready_d = 1'b0;
                if (rsp_valid_q && rsp_ready_i) begin
                    // ready is back next cycle; no same-cycle command bypass
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wishbone_cmd_master.sv
// Directed bench for wishbone_cmd_master with a one-cycle-ack register slave.
// Each expected response is pushed to a queue when its command is issued.
// The entry is popped and compared when the response appears.
module tb_wishbone_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = 4'h0;
    logic [31:0] cmd_adr = 32'h0;
    logic [31:0] cmd_dat = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr, wbm_dat_o;
    logic        wbm_ack;
    logic [31:0] wbm_dat_i;
    logic [1:0]  dbg_state;

    // slave environment
    logic        ack_en = 1'b1;
    logic        stray_ack = 1'b0;
    logic        s_ack;
    logic [31:0] s_rdat;
    logic [31:0] s_mem [16];

    // bench bookkeeping
    int          errors = 0;
    int          checks = 0;
    int          cyc_cnt = 0;
    int          stb_rise = 0;
    int          stb_high = 0;
    int          ack_cnt = 0;
    logic        stb_prev = 1'b0;
    logic [31:0] model_mem [16];
    logic [32:0] exp_q [$];

    wishbone_cmd_master #(.ADR_W(32), .TIMEOUT(16), .TO_W(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_sel_i   (cmd_sel),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack),
        .wbm_dat_i   (wbm_dat_i),
        .dbg_state_o (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // register slave: acks one cycle after it sees a strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack  <= 1'b0;
            s_rdat <= 32'h0;
        end else begin
            s_ack <= 1'b0;
            if (wbm_cyc && wbm_stb && !s_ack && ack_en) begin
                s_ack  <= 1'b1;
                s_rdat <= s_mem[wbm_adr[5:2]];
                if (wbm_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wbm_sel[b]) s_mem[wbm_adr[5:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
                    end
                end
            end
        end
    end

    assign wbm_ack   = s_ack | stray_ack;
    assign wbm_dat_i = s_rdat;

    // cycle and strobe activity counters
    always @(posedge clk) begin
        cyc_cnt  <= cyc_cnt + 1;
        stb_prev <= wbm_stb;
        if (wbm_stb && !stb_prev) stb_rise <= stb_rise + 1;
        if (wbm_stb) stb_high <= stb_high + 1;
        if (s_ack) ack_cnt <= ack_cnt + 1;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command; returns the cycle stamp of the accept edge.
    task automatic send_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat, input bit keep, input bit expect_to,
                            output int acc);
        bit got;
        cmd_we    = we;
        cmd_sel   = sel;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_valid = 1'b1;
        if (expect_to) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) model_mem[adr[5:2]][8*b +: 8] = dat[8*b +: 8];
            end
            exp_q.push_back({1'b0, 32'h0});
        end else begin
            exp_q.push_back({1'b0, model_mem[adr[5:2]]});
        end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check("cmd_accept", 64'(got), 64'd1);
            cmd_valid = 1'b0;
            acc = cyc_cnt;
            return;
        end
        @(negedge clk);
        acc = cyc_cnt;
        if (!keep) cmd_valid = 1'b0;
        check("bus_cyc", 64'(wbm_cyc), 64'd1);
        check("bus_stb", 64'(wbm_stb), 64'd1);
        check("bus_we", 64'(wbm_we), 64'(we));
        check("bus_sel", 64'(wbm_sel), 64'(sel));
        check("bus_adr", 64'(wbm_adr), 64'(adr));
        check("bus_dat", 64'(wbm_dat_o), we ? 64'(dat) : 64'd0);
        check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    endtask

    // Wait for a response, compare it with the queue head, consume it if rsp_ready is high.
    task automatic collect(input string tag, input int acc, input int max, output int lat);
        bit got;
        logic [32:0] e;
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        lat = cyc_cnt - acc;
        if (!got) begin
            check({tag, "_rsp_wait"}, 64'(got), 64'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_rsp"}, 64'(exp_q.size()), 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_rsp"}, 64'({rsp_err, rsp_dat}), 64'(e));
        if (rsp_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int acc, lat, prev_acc, base_rise, base_ack, base_high;
        logic [32:0] held;
        bit bad;

        // reset state
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_cyc", 64'(wbm_cyc), 64'd0);
        check("rst_stb", 64'(wbm_stb), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp", 64'({rsp_err, rsp_dat}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("rel_cmd_ready_high", 64'(cmd_ready), 64'd1);

        // 1: full write then read back, with latency
        send_cmd(1'b1, 4'hF, 32'h0, 32'h12345678, 1'b0, 1'b0, acc);
        collect("t1_wr", acc, 20, lat);
        send_cmd(1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        collect("t1_rd", acc, 20, lat);
        check("t1_latency", 64'(lat), 64'd2);

        // stray ACK while idle must be ignored
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check("stray_rsp_valid", 64'(rsp_valid), 64'd0);
        check("stray_cmd_ready", 64'(cmd_ready), 64'd1);
        check("stray_state", 64'(dbg_state), 64'd0);

        // 2: byte-lane write then read back
        send_cmd(1'b1, 4'h2, 32'h0, 32'hAABBCCDD, 1'b0, 1'b0, acc);
        collect("t2_wr", acc, 20, lat);
        send_cmd(1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        collect("t2_rd", acc, 20, lat);

        // 3: slave never acks -> timeout after 16 strobe cycles
        ack_en = 1'b0;
        base_high = stb_high;
        send_cmd(1'b0, 4'hF, 32'h8, 32'h0, 1'b0, 1'b1, acc);
        collect("t3_to", acc, 40, lat);
        check("t3_latency", 64'(lat), 64'd16);
        check("t3_stb_cycles", 64'(stb_high - base_high), 64'd16);
        check("t3_cyc_off", 64'(wbm_cyc), 64'd0);
        check("t3_stb_off", 64'(wbm_stb), 64'd0);
        ack_en = 1'b1;

        // 4: response back-pressure
        send_cmd(1'b1, 4'hF, 32'h4, 32'hCAFEF00D, 1'b0, 1'b0, acc);
        collect("t4_wr", acc, 20, lat);
        rsp_ready = 1'b0;
        send_cmd(1'b0, 4'hF, 32'h4, 32'h0, 1'b0, 1'b0, acc);
        collect("t4_rd", acc, 20, lat);
        held = {rsp_err, rsp_dat};
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || {rsp_err, rsp_dat} !== held || cmd_ready !== 1'b0 || wbm_cyc !== 1'b0)
                bad = 1'b1;
        end
        check("t4_hold_stable", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_rsp_released", 64'(rsp_valid), 64'd0);
        check("t4_cmd_ready", 64'(cmd_ready), 64'd1);

        // 5: reset while strobe is high
        ack_en = 1'b0;
        send_cmd(1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        repeat (3) @(negedge clk);
        check("t5_stb_before", 64'(wbm_stb), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_cyc_rst", 64'(wbm_cyc), 64'd0);
        check("t5_stb_rst", 64'(wbm_stb), 64'd0);
        check("t5_rsp_valid_rst", 64'(rsp_valid), 64'd0);
        check("t5_cmd_ready_rst", 64'(cmd_ready), 64'd0);
        void'(exp_q.pop_back());
        ack_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_cmd_ready_after", 64'(cmd_ready), 64'd1);
        send_cmd(1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        collect("t5_rd", acc, 20, lat);

        // 6: eight back-to-back commands with cmd_valid held
        base_rise = stb_rise;
        base_ack  = ack_cnt;
        prev_acc  = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4)
                send_cmd(1'b1, 4'hF, 32'(4 * (i + 1)), $urandom, (i < 7), 1'b0, acc);
            else
                send_cmd(1'b0, 4'hF, 32'(4 * (i - 3)), 32'h0, (i < 7), 1'b0, acc);
            if (i > 0) check("t6_spacing", 64'(acc - prev_acc), 64'd4);
            prev_acc = acc;
            collect("t6", acc, 20, lat);
        end
        cmd_valid = 1'b0;
        check("t6_stb_windows", 64'(stb_rise - base_rise), 64'd8);
        check("t6_acks", 64'(ack_cnt - base_ack), 64'd8);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("t6_idle_after", 64'(rsp_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
